// File: rtl/fifo_wr_serializer_if.sv
// Stream-in / FIFO-write-out signal bundle for the write-side serializer.
// The slave modport is the serializer's view; master is the surrounding logic.
interface fifo_wr_serializer_if #(
    parameter int IN_WIDTH   = 32,
    parameter int DATA_WIDTH = 8
);
    logic                  s_valid;
    logic                  s_ready;
    logic [IN_WIDTH-1:0]   s_data;
    logic                  full;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;

    modport slave (
        input  s_valid, s_data, full,
        output s_ready, wr_en, wr_data
    );

    modport master (
        output s_valid, s_data, full,
        input  s_ready, wr_en, wr_data
    );
endinterface

// File: rtl/fifo_wr_serializer.sv
// Write-side feeder for the async FIFO: splits each IN_WIDTH word into
// DATA_WIDTH beats, never writes while full, and counts beats written.
module fifo_wr_serializer #(
    parameter int IN_WIDTH   = 32,
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  wr_clk,
    input  logic                  wr_rst_n,
    fifo_wr_serializer_if.slave   bus,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  beat_cnt
);
    localparam int N     = IN_WIDTH / DATA_WIDTH;
    localparam int IDX_W = $clog2(N);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic [IN_WIDTH-1:0] sh;
    logic                last_beat;
    logic                accept;

    function automatic logic [IN_WIDTH-1:0] shift_beat(input logic [IN_WIDTH-1:0] v);
        return MSB_FIRST ? (v << DATA_WIDTH) : (v >> DATA_WIDTH);
    endfunction

    assign busy        = (state == SEND);
    assign last_beat   = (idx == IDX_W'(N - 1));
    assign bus.wr_en   = busy & ~bus.full;
    // The final beat and the next word's accept share a cycle, so words stream without a bubble.
    assign bus.s_ready = ~busy | (bus.wr_en & last_beat);
    assign accept      = bus.s_valid & bus.s_ready;

    generate
        if (MSB_FIRST) begin : g_msb
            assign bus.wr_data = sh[IN_WIDTH-1 -: DATA_WIDTH];
        end else begin : g_lsb
            assign bus.wr_data = sh[DATA_WIDTH-1:0];
        end
    endgenerate

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            sh       <= '0;
            beat_cnt <= '0;
        end else begin
            if (accept) begin
                sh    <= bus.s_data;
                idx   <= '0;
                state <= SEND;
            end else if (bus.wr_en) begin
                if (last_beat) begin
                    state <= IDLE;
                end else begin
                    idx <= idx + IDX_W'(1);
                    sh  <= shift_beat(sh);
                end
            end
            if (bus.wr_en) begin
                beat_cnt <= beat_cnt + CNT_WIDTH'(1);
            end
        end
    end

    a_no_write_when_full: assert property (@(posedge wr_clk) disable iff (!wr_rst_n)
        !(bus.wr_en && bus.full));
    a_idle_no_write: assert property (@(posedge wr_clk) disable iff (!wr_rst_n)
        !busy |-> !bus.wr_en);
    a_idx_range: assert property (@(posedge wr_clk) disable iff (!wr_rst_n)
        int'(idx) < N);
    a_data_stable_on_full: assert property (@(posedge wr_clk) disable iff (!wr_rst_n)
        (busy && bus.full) |=> $stable(bus.wr_data));
endmodule
